// File: rtl/im_ctrl_pkg.sv
// Shared constants and state encoding for the instruction-memory controller.
package im_ctrl_pkg;

    localparam int unsigned IM_AW    = 6;
    localparam int unsigned IM_DW    = 32;
    localparam int unsigned IM_DEPTH = 64;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        LOAD  = 2'd1,
        RUN   = 2'd2
    } im_state_e;

endpackage

// File: rtl/im_ctrl_if.sv
// Host-loader stream, CPU fetch port and instruction-memory port of im_ctrl.
interface im_ctrl_if
    import im_ctrl_pkg::*;
#(
    parameter int unsigned AW = IM_AW,
    parameter int unsigned DW = IM_DW
) ();

    logic          ld_start;
    logic          ld_valid;
    logic [DW-1:0] ld_data;
    logic          ld_last;
    logic          ld_ready;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_data;
    logic          cpu_stall;
    logic          fetch_oob;
    logic [AW:0]   prog_len;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  ld_start, ld_valid, ld_data, ld_last, cpu_addr, mem_rdata,
        output ld_ready, cpu_data, cpu_stall, fetch_oob, prog_len,
               mem_addr, mem_we, mem_wdata
    );

    modport master (
        output ld_start, ld_valid, ld_data, ld_last, cpu_addr, mem_rdata,
        input  ld_ready, cpu_data, cpu_stall, fetch_oob, prog_len,
               mem_addr, mem_we, mem_wdata
    );

endinterface

// File: rtl/im_wr_seq.sv
// Write pointer shared by the zero-fill and program-load phases.
module im_wr_seq
    import im_ctrl_pkg::*;
#(
    parameter int unsigned AW    = IM_AW,
    parameter int unsigned DEPTH = IM_DEPTH
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          inc_i,
    input  logic          clr_i,
    output logic [AW-1:0] ptr_o,
    output logic          wrap_o
);

    logic [AW-1:0] ptr_q, ptr_d;
    logic          wrap_q, wrap_d;

    // Clear wins over increment; increment wraps modulo DEPTH.
    always_comb begin
        ptr_d = ptr_q;
        if (clr_i) begin
            ptr_d = '0;
        end else if (inc_i) begin
            ptr_d = ptr_q + AW'(1);
        end
        wrap_d = (ptr_d == AW'(DEPTH - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q  <= '0;
            wrap_q <= 1'b0;
        end else begin
            ptr_q  <= ptr_d;
            wrap_q <= wrap_d;
        end
    end

    assign ptr_o  = ptr_q;
    assign wrap_o = wrap_q;

endmodule

// File: rtl/im_ctrl.sv
// Instruction-memory sequencer: zero-fill, host program load, then CPU fetch.
module im_ctrl
    import im_ctrl_pkg::*;
#(
    parameter int unsigned AW    = IM_AW,
    parameter int unsigned DW    = IM_DW,
    parameter int unsigned DEPTH = IM_DEPTH
) (
    input  logic       clk,
    input  logic       rst_n,
    im_ctrl_if.slave   im_bus
);

    localparam int unsigned LW = AW + 1;

    im_state_e     state_q, state_d;
    logic [LW-1:0] prog_len_q, prog_len_d;
    logic          oob_q, oob_d;

    logic [AW-1:0] ptr;
    logic          wrap;
    logic          inc_c, clr_c;

    logic          ld_ready_c;
    logic          mem_we_c;
    logic [AW-1:0] mem_addr_c;
    logic [DW-1:0] mem_wdata_c;
    logic          cpu_stall_c;
    logic [DW-1:0] cpu_data_c;

    im_wr_seq #(
        .AW    (AW),
        .DEPTH (DEPTH)
    ) u_wr_seq (
        .clk    (clk),
        .rst_n  (rst_n),
        .inc_i  (inc_c),
        .clr_i  (clr_c),
        .ptr_o  (ptr),
        .wrap_o (wrap)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= CLEAR;
            prog_len_q <= '0;
            oob_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            prog_len_q <= prog_len_d;
            oob_q      <= oob_d;
        end
    end

    // Next-state, pointer control and memory/CPU port muxing.
    always_comb begin
        state_d     = state_q;
        prog_len_d  = prog_len_q;
        oob_d       = oob_q;
        inc_c       = 1'b0;
        clr_c       = 1'b0;
        ld_ready_c  = 1'b0;
        mem_we_c    = 1'b0;
        mem_addr_c  = ptr;
        mem_wdata_c = '0;
        cpu_stall_c = 1'b1;
        cpu_data_c  = '0;

        case (state_q)
            CLEAR: begin
                mem_we_c = 1'b1;
                inc_c    = 1'b1;
                if (wrap) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                ld_ready_c = 1'b1;
                if (im_bus.ld_valid) begin
                    mem_we_c    = 1'b1;
                    mem_wdata_c = im_bus.ld_data;
                    inc_c       = 1'b1;
                    prog_len_d  = LW'(ptr) + LW'(1);
                    if (im_bus.ld_last || wrap) begin
                        clr_c   = 1'b1;
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                mem_addr_c  = im_bus.cpu_addr;
                cpu_stall_c = 1'b0;
                cpu_data_c  = im_bus.mem_rdata;
                if (LW'(im_bus.cpu_addr) >= prog_len_q) begin
                    oob_d = 1'b1;
                end
                if (im_bus.ld_start) begin
                    state_d    = CLEAR;
                    prog_len_d = '0;
                    oob_d      = 1'b0;
                end
            end
            default: begin
                state_d = CLEAR;
            end
        endcase
    end

    // Reset sits in CLEAR, so the write strobe is gated to stay quiet while rst_n is low.
    assign im_bus.mem_we    = mem_we_c & rst_n;
    assign im_bus.mem_addr  = mem_addr_c;
    assign im_bus.mem_wdata = mem_wdata_c;
    assign im_bus.ld_ready  = ld_ready_c;
    assign im_bus.cpu_stall = cpu_stall_c;
    assign im_bus.cpu_data  = cpu_data_c;
    assign im_bus.prog_len  = prog_len_q;
    assign im_bus.fetch_oob = oob_q;

endmodule

// File: tb/tb_im_ctrl.sv
// Directed bench for im_ctrl: vector table for load/run plus hand sequences.
module tb_im_ctrl;

    logic clk;
    logic rst_n;

    im_ctrl_if im_if ();

    im_ctrl dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .im_bus (im_if)
    );

    // Instruction memory model: synchronous write, combinational read.
    logic [31:0] mem [64];
    always @(posedge clk) begin
        if (im_if.mem_we) mem[im_if.mem_addr] <= im_if.mem_wdata;
    end
    assign im_if.mem_rdata = mem[im_if.mem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [31:0] data;
        logic        last;
        logic [5:0]  cpu_addr;
        logic        start;
        logic        e_ready;
        logic        e_we;
        logic [5:0]  e_addr;
        logic [31:0] e_wdata;
        logic        e_stall;
        logic [31:0] e_cpu_data;
        logic [6:0]  e_len;
        logic        e_oob;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h want %0h", nm, $time, act, exp);
        end
    endtask

    function automatic void add(input logic v, input logic [31:0] d, input logic l,
                                input logic [5:0] ca, input logic st,
                                input logic er, input logic ew, input logic [5:0] ea,
                                input logic [31:0] ewd, input logic es,
                                input logic [31:0] ecd, input logic [6:0] el, input logic eo);
        vec_t t;
        t.valid = v;  t.data = d;  t.last = l;  t.cpu_addr = ca;  t.start = st;
        t.e_ready = er;  t.e_we = ew;  t.e_addr = ea;  t.e_wdata = ewd;
        t.e_stall = es;  t.e_cpu_data = ecd;  t.e_len = el;  t.e_oob = eo;
        tbl.push_back(t);
    endfunction

    // Called at a negedge in CLEAR with pointer at 'first'; returns at the negedge entering LOAD.
    task automatic clear_check(input int first);
        for (int i = first; i < 64; i++) begin
            #1;
            if (i == first) begin
                chk("clr_len", 64'(im_if.prog_len), 64'd0);
                chk("clr_oob", 64'(im_if.fetch_oob), 64'd0);
            end
            chk("clr_we", 64'(im_if.mem_we), 64'd1);
            chk("clr_addr", 64'(im_if.mem_addr), 64'(i));
            chk("clr_wdata", 64'(im_if.mem_wdata), 64'd0);
            chk("clr_ready", 64'(im_if.ld_ready), 64'd0);
            chk("clr_stall", 64'(im_if.cpu_stall), 64'd1);
            @(negedge clk);
        end
    endtask

    initial begin
        rst_n          = 1'b0;
        im_if.ld_start = 1'b0;
        im_if.ld_valid = 1'b0;
        im_if.ld_data  = '0;
        im_if.ld_last  = 1'b0;
        im_if.cpu_addr = '0;

        // Load 16 words with a 5-cycle gap, then fetch in RUN.
        for (int k = 0; k < 8; k++)
            add(1, 32'h20080020 + 32'(k), 0, 0, 0, 1, 1, 6'(k), 32'h20080020 + 32'(k), 1, 0, 7'(k), 0);
        for (int j = 0; j < 5; j++)
            add(0, 32'h0BAD0000 + 32'(j), 0, 0, 0, 1, 0, 6'd8, 0, 1, 0, 7'd8, 0);
        for (int k = 8; k < 16; k++)
            add(1, 32'h20080020 + 32'(k), (k == 15), 0, 0, 1, 1, 6'(k), 32'h20080020 + 32'(k), 1, 0, 7'(k), 0);
        add(1, 32'h0BAD, 0, 6'd2,  0, 0, 0, 6'd2,  0, 0, 32'h20080022, 7'd16, 0);
        add(1, 32'h0BAD, 0, 6'd15, 0, 0, 0, 6'd15, 0, 0, 32'h2008002F, 7'd16, 0);
        add(1, 32'h0BAD, 0, 6'd20, 0, 0, 0, 6'd20, 0, 0, 32'h00000000, 7'd16, 0);
        add(1, 32'h0BAD, 0, 6'd3,  0, 0, 0, 6'd3,  0, 0, 32'h20080023, 7'd16, 1);
        add(1, 32'h0BAD, 0, 6'd1,  0, 0, 0, 6'd1,  0, 0, 32'h20080021, 7'd16, 1);
        add(1, 32'h0BAD, 0, 6'd5,  1, 0, 0, 6'd5,  0, 0, 32'h20080025, 7'd16, 1);

        // Reset state.
        #3;
        chk("rst_we", 64'(im_if.mem_we), 64'd0);
        chk("rst_ready", 64'(im_if.ld_ready), 64'd0);
        chk("rst_stall", 64'(im_if.cpu_stall), 64'd1);
        chk("rst_cpu_data", 64'(im_if.cpu_data), 64'd0);
        chk("rst_len", 64'(im_if.prog_len), 64'd0);
        chk("rst_oob", 64'(im_if.fetch_oob), 64'd0);

        // Zero-fill with loader inputs active; they must be ignored.
        @(negedge clk);
        rst_n          = 1'b1;
        im_if.ld_valid = 1'b1;
        im_if.ld_start = 1'b1;
        im_if.ld_data  = 32'hFFFF_FFFF;
        clear_check(0);
        im_if.ld_valid = 1'b0;
        im_if.ld_start = 1'b0;
        #1;
        chk("load_ready", 64'(im_if.ld_ready), 64'd1);
        chk("load_idle_we", 64'(im_if.mem_we), 64'd0);
        chk("load_stall", 64'(im_if.cpu_stall), 64'd1);
        chk("load_addr", 64'(im_if.mem_addr), 64'd0);

        foreach (tbl[n]) begin
            @(negedge clk);
            im_if.ld_valid = tbl[n].valid;
            im_if.ld_data  = tbl[n].data;
            im_if.ld_last  = tbl[n].last;
            im_if.cpu_addr = tbl[n].cpu_addr;
            im_if.ld_start = tbl[n].start;
            #1;
            chk($sformatf("v%0d_ready", n), 64'(im_if.ld_ready), 64'(tbl[n].e_ready));
            chk($sformatf("v%0d_we", n), 64'(im_if.mem_we), 64'(tbl[n].e_we));
            chk($sformatf("v%0d_addr", n), 64'(im_if.mem_addr), 64'(tbl[n].e_addr));
            if (tbl[n].e_we)
                chk($sformatf("v%0d_wdata", n), 64'(im_if.mem_wdata), 64'(tbl[n].e_wdata));
            chk($sformatf("v%0d_stall", n), 64'(im_if.cpu_stall), 64'(tbl[n].e_stall));
            chk($sformatf("v%0d_cpu_data", n), 64'(im_if.cpu_data), 64'(tbl[n].e_cpu_data));
            chk($sformatf("v%0d_len", n), 64'(im_if.prog_len), 64'(tbl[n].e_len));
            chk($sformatf("v%0d_oob", n), 64'(im_if.fetch_oob), 64'(tbl[n].e_oob));
        end

        // Reload after ld_start; then full 64-word load without ld_last.
        @(negedge clk);
        im_if.ld_start = 1'b0;
        im_if.ld_last  = 1'b0;
        clear_check(0);
        for (int k = 0; k < 64; k++) begin
            im_if.ld_valid = 1'b1;
            im_if.ld_data  = 32'h40000000 + 32'(k);
            #1;
            chk("full_we", 64'(im_if.mem_we), 64'd1);
            chk("full_addr", 64'(im_if.mem_addr), 64'(k));
            @(negedge clk);
        end
        im_if.cpu_addr = 6'd63;
        #1;
        chk("full_ready", 64'(im_if.ld_ready), 64'd0);
        chk("full_no65_we", 64'(im_if.mem_we), 64'd0);
        chk("full_stall", 64'(im_if.cpu_stall), 64'd0);
        chk("full_len", 64'(im_if.prog_len), 64'd64);
        chk("full_fetch63", 64'(im_if.cpu_data), 64'h4000003F);
        @(negedge clk);
        im_if.cpu_addr = 6'd0;
        #1;
        chk("full_oob63", 64'(im_if.fetch_oob), 64'd0);
        chk("full_fetch0", 64'(im_if.cpu_data), 64'h40000000);

        // ld_last on the very first beat.
        @(negedge clk);
        im_if.ld_valid = 1'b0;
        im_if.ld_start = 1'b1;
        @(negedge clk);
        im_if.ld_start = 1'b0;
        clear_check(0);
        im_if.ld_valid = 1'b1;
        im_if.ld_data  = 32'h11111111;
        im_if.ld_last  = 1'b1;
        #1;
        chk("one_we", 64'(im_if.mem_we), 64'd1);
        chk("one_addr", 64'(im_if.mem_addr), 64'd0);
        @(negedge clk);
        im_if.ld_valid = 1'b0;
        im_if.ld_last  = 1'b0;
        im_if.cpu_addr = 6'd0;
        #1;
        chk("one_len", 64'(im_if.prog_len), 64'd1);
        chk("one_stall", 64'(im_if.cpu_stall), 64'd0);
        chk("one_fetch", 64'(im_if.cpu_data), 64'h11111111);
        @(negedge clk);
        im_if.cpu_addr = 6'd1;
        #1;
        chk("one_oob_pre", 64'(im_if.fetch_oob), 64'd0);
        @(negedge clk);
        im_if.cpu_addr = 6'd0;
        #1;
        chk("one_oob_set", 64'(im_if.fetch_oob), 64'd1);

        // Asynchronous reset during load beat 7.
        @(negedge clk);
        im_if.ld_start = 1'b1;
        @(negedge clk);
        im_if.ld_start = 1'b0;
        clear_check(0);
        for (int k = 0; k < 7; k++) begin
            im_if.ld_valid = 1'b1;
            im_if.ld_data  = 32'h55550000 + 32'(k);
            @(negedge clk);
        end
        im_if.ld_data = 32'h55550007;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_ready", 64'(im_if.ld_ready), 64'd0);
        chk("arst_we", 64'(im_if.mem_we), 64'd0);
        chk("arst_stall", 64'(im_if.cpu_stall), 64'd1);
        chk("arst_len", 64'(im_if.prog_len), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        clear_check(0);
        im_if.ld_data = 32'h77777777;
        im_if.ld_last = 1'b1;
        @(negedge clk);
        im_if.ld_valid = 1'b0;
        im_if.ld_last  = 1'b0;
        im_if.cpu_addr = 6'd3;
        #1;
        chk("arst_len1", 64'(im_if.prog_len), 64'd1);
        chk("arst_overwritten", 64'(im_if.cpu_data), 64'd0);
        im_if.cpu_addr = 6'd0;
        #1;
        chk("arst_fetch0", 64'(im_if.cpu_data), 64'h77777777);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
